// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS core: sequences fetch/decode/execute over a
// shared ALU and unified memory, counts retired instructions, halts on bad opcodes.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic [3:0]       state_o,
  output logic             trap_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] retired_r;
  logic             retire_s;

  logic       pc_write_s, pc_write_cond_s, iord_s, mem_read_s, mem_write_s;
  logic       ir_write_s, memto_reg_s, reg_dst_s, reg_write_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, pc_source_s;
  logic [2:0] alu_op_s;

  // State register and retired-instruction counter (wraps silently).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r   <= S_FETCH;
      retired_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (retire_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state decode and per-state control fields.
  always_comb begin
    state_nxt_s     = state_r;
    retire_s        = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    iord_s          = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    memto_reg_s     = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = 2'b00;
    alu_op_s        = 3'b000;
    pc_source_s     = 2'b00;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = 2'b01;
        ir_write_s  = mem_ready_i;
        pc_write_s  = mem_ready_i;
        state_nxt_s = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_s = 2'b11;
        case (opcode_i)
          OP_RTYPE:        state_nxt_s = S_R_EXEC;
          OP_LW, OP_SW:    state_nxt_s = S_MEM_ADDR;
          OP_BEQ:          state_nxt_s = S_BRANCH;
          OP_J:            state_nxt_s = S_JUMP;
          OP_ADDI, OP_SLTI: state_nxt_s = S_I_EXEC;
          default:         state_nxt_s = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        // IR is stable here, so anything but lw/sw means a corrupted path.
        if (opcode_i == OP_LW) begin
          state_nxt_s = S_MEM_READ;
        end else if (opcode_i == OP_SW) begin
          state_nxt_s = S_MEM_WRITE;
        end else begin
          state_nxt_s = S_TRAP;
        end
      end
      S_MEM_READ: begin
        mem_read_s  = 1'b1;
        iord_s      = 1'b1;
        state_nxt_s = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        reg_write_s = 1'b1;
        memto_reg_s = 1'b1;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        retire_s    = mem_ready_i;
        state_nxt_s = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = 3'b010;
        state_nxt_s = S_R_WB;
      end
      S_R_WB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 1'b1;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = 3'b001;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'b01;
        retire_s        = 1'b1;
        state_nxt_s     = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'b10;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'b10;
        if (opcode_i == OP_SLTI) begin
          alu_op_s = 3'b011;
        end else begin
          alu_op_s = 3'b000;
        end
        state_nxt_s = S_I_WB;
      end
      S_I_WB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_TRAP: begin
        state_nxt_s = S_TRAP;
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  // Controls are forced idle during a reset cycle so no access or write leaks out.
  assign PCWrite_o     = rst_i & pc_write_s;
  assign PCWriteCond_o = rst_i & pc_write_cond_s;
  assign IorD_o        = rst_i & iord_s;
  assign MemRead_o     = rst_i & mem_read_s;
  assign MemWrite_o    = rst_i & mem_write_s;
  assign IRWrite_o     = rst_i & ir_write_s;
  assign MemtoReg_o    = rst_i & memto_reg_s;
  assign RegDst_o      = rst_i & reg_dst_s;
  assign RegWrite_o    = rst_i & reg_write_s;
  assign ALUSrcA_o     = rst_i & alu_src_a_s;
  assign ALUSrcB_o     = rst_i ? alu_src_b_s : 2'b00;
  assign ALUOp_o       = rst_i ? alu_op_s    : 3'b000;
  assign PCSource_o    = rst_i ? pc_source_s : 2'b00;
  assign state_o       = state_r;
  assign trap_o        = (state_r == S_TRAP);
  assign retired_o     = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + randomized bench for multicycle_ctrl; expected state traces and
// control words come from a per-instruction reference model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        rdy = 1'b0;

  logic        pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, sa;
  logic [1:0]  sb, ps;
  logic [2:0]  aop;
  logic [3:0]  st;
  logic        trap;
  logic [31:0] ret32;

  logic        n_pcw, n_pcwc, n_iord, n_mrd, n_mwr, n_irw, n_m2r, n_rdst, n_rwr, n_sa;
  logic [1:0]  n_sb, n_ps;
  logic [2:0]  n_aop;
  logic [3:0]  n_st;
  logic        n_trap;
  logic [3:0]  ret4;

  int          total = 0;
  int          bad = 0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(rdy),
    .PCWrite_o(pcw), .PCWriteCond_o(pcwc), .IorD_o(iord), .MemRead_o(mrd),
    .MemWrite_o(mwr), .IRWrite_o(irw), .MemtoReg_o(m2r), .RegDst_o(rdst),
    .RegWrite_o(rwr), .ALUSrcA_o(sa), .ALUSrcB_o(sb), .ALUOp_o(aop),
    .PCSource_o(ps), .state_o(st), .trap_o(trap), .retired_o(ret32)
  );

  // Narrow-counter instance shares all stimulus to exercise counter wrap.
  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(rdy),
    .PCWrite_o(n_pcw), .PCWriteCond_o(n_pcwc), .IorD_o(n_iord), .MemRead_o(n_mrd),
    .MemWrite_o(n_mwr), .IRWrite_o(n_irw), .MemtoReg_o(n_m2r), .RegDst_o(n_rdst),
    .RegWrite_o(n_rwr), .ALUSrcA_o(n_sa), .ALUSrcB_o(n_sb), .ALUOp_o(n_aop),
    .PCSource_o(n_ps), .state_o(n_st), .trap_o(n_trap), .retired_o(ret4)
  );

  // Control word order: pcw pcwc iord mrd mwr irw m2r rdst rwr sa sb[2] aop[3] ps[2]
  function automatic logic [16:0] exp_ctrl(input logic [3:0] s, input logic r,
                                           input logic [5:0] op);
    logic c_pcw, c_pcwc, c_iord, c_mrd, c_mwr, c_irw, c_m2r, c_rdst, c_rwr, c_sa;
    logic [1:0] c_sb, c_ps;
    logic [2:0] c_aop;
    {c_pcw, c_pcwc, c_iord, c_mrd, c_mwr, c_irw, c_m2r, c_rdst, c_rwr, c_sa} = 10'd0;
    c_sb = 2'b00; c_ps = 2'b00; c_aop = 3'b000;
    case (s)
      4'd0:  begin c_mrd = 1'b1; c_sb = 2'b01; c_pcw = r; c_irw = r; end
      4'd1:  c_sb = 2'b11;
      4'd2:  begin c_sa = 1'b1; c_sb = 2'b10; end
      4'd3:  begin c_mrd = 1'b1; c_iord = 1'b1; end
      4'd4:  begin c_rwr = 1'b1; c_m2r = 1'b1; end
      4'd5:  begin c_mwr = 1'b1; c_iord = 1'b1; end
      4'd6:  begin c_sa = 1'b1; c_aop = 3'b010; end
      4'd7:  begin c_rwr = 1'b1; c_rdst = 1'b1; end
      4'd8:  begin c_sa = 1'b1; c_aop = 3'b001; c_pcwc = 1'b1; c_ps = 2'b01; end
      4'd9:  begin c_pcw = 1'b1; c_ps = 2'b10; end
      4'd10: begin c_sa = 1'b1; c_sb = 2'b10; c_aop = (op == 6'b001010) ? 3'b011 : 3'b000; end
      4'd11: c_rwr = 1'b1;
      default: ;
    endcase
    return {c_pcw, c_pcwc, c_iord, c_mrd, c_mwr, c_irw, c_m2r, c_rdst, c_rwr, c_sa,
            c_sb, c_aop, c_ps};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive ready, check all outputs mid-cycle, advance past the edge.
  task automatic cycle(input logic [3:0] exp_st, input logic r);
    logic [16:0] ctrl_exp;
    rdy = r;
    @(negedge clk);
    ctrl_exp = rst ? exp_ctrl(exp_st, r, opcode) : 17'd0;
    check("state", 32'(st), 32'(exp_st));
    check("ctrl", 32'({pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, sa, sb, aop, ps}),
          32'(ctrl_exp));
    check("trap", 32'(trap), 32'(exp_st == 4'd12));
    check("retired", ret32, model_cnt);
    check("retired4", 32'(ret4), model_cnt % 32'd16);
    check("state4", 32'(n_st), 32'(exp_st));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Runs one instruction with fw not-ready fetch cycles and mw not-ready memory cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    opcode = op;
    for (int i = 0; i < fw; i++) cycle(4'd0, 1'b0);
    cycle(4'd0, 1'b1);
    cycle(4'd1, rnd());
    case (op)
      6'b000000: begin cycle(4'd6, rnd()); cycle(4'd7, rnd()); model_cnt++; end
      6'b100011: begin
        cycle(4'd2, rnd());
        for (int i = 0; i < mw; i++) cycle(4'd3, 1'b0);
        cycle(4'd3, 1'b1);
        cycle(4'd4, rnd());
        model_cnt++;
      end
      6'b101011: begin
        cycle(4'd2, rnd());
        for (int i = 0; i < mw; i++) cycle(4'd5, 1'b0);
        cycle(4'd5, 1'b1);
        model_cnt++;
      end
      6'b000100: begin cycle(4'd8, rnd()); model_cnt++; end
      6'b000010: begin cycle(4'd9, rnd()); model_cnt++; end
      6'b001000, 6'b001010: begin cycle(4'd10, rnd()); cycle(4'd11, rnd()); model_cnt++; end
      default: for (int i = 0; i < 20; i++) cycle(4'd12, rnd());
    endcase
  endtask

  logic [5:0] legal_ops [7];

  initial begin
    legal_ops[0] = 6'b000000; legal_ops[1] = 6'b100011; legal_ops[2] = 6'b101011;
    legal_ops[3] = 6'b000100; legal_ops[4] = 6'b000010; legal_ops[5] = 6'b001000;
    legal_ops[6] = 6'b001010;

    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(4'd0, 1'b1);
    rst = 1'b1;

    run_instr(6'b000000, 0, 0);
    check("r_retire", ret32, 32'd1);
    run_instr(6'b100011, 2, 3);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    check("swbeqj_retire", ret32, 32'd5);
    run_instr(6'b001010, 0, 0);
    run_instr(6'b001000, 0, 0);

    for (int k = 0; k < 30; k++) begin
      run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2));
    end

    run_instr(6'b111111, 1, 0);
    rst = 1'b0;
    cycle(4'd12, 1'b1);
    rst = 1'b1;
    model_cnt = 0;
    opcode = 6'b100011;
    cycle(4'd0, 1'b1);
    cycle(4'd1, rnd());
    cycle(4'd2, rnd());
    cycle(4'd3, 1'b0);
    rst = 1'b0;
    cycle(4'd3, 1'b0);
    rst = 1'b1;
    cycle(4'd0, 1'b0);
    cycle(4'd0, 1'b1);
    cycle(4'd1, rnd());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
